// File: rtl/audio_nios_sd_spi_pkg.sv
// Shared definitions for the SD-card SPI byte engine: register map,
// STATUS/CONTROL bit positions and the bit-clock FSM states.
package audio_nios_sd_spi_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_DIVIDER = 2'd3;

  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_DONE_BIT    = 1;
  localparam int CONTROL_CS_N_BIT   = 0;
  localparam int CONTROL_IRQ_EN_BIT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_state_t;

endpackage

// File: rtl/audio_nios_sd_spi_clkdiv.sv
// Half-period tick generator for sd_clk. While run is low the counter is
// parked at div, so the first tick after run rises comes div+1 cycles later.
module audio_nios_sd_spi_clkdiv #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = run && (cnt == '0);

  // Down-counter; reloads on terminal count or whenever the engine is idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= div;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/audio_nios_sd_spi_ctrl.sv
// SD-card SPI-mode (mode 0, MSB first) byte engine on Avalon-MM.
// Optional interrupt output is compiled in with SD_SPI_CTRL_IRQ_EN.
//
// state | meaning
// IDLE  | sd_clk low, divider parked, waiting for a DATA write
// LOW   | sd_clk low half period, current bit on sd_mosi
// HIGH  | sd_clk high half period, sd_miso already captured
module audio_nios_sd_spi_ctrl
  import audio_nios_sd_spi_pkg::*;
#(
  parameter int          DIV_W     = 16,
  parameter int unsigned DIV_RESET = 99
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sd_clk,
  output logic        sd_mosi,
  input  logic        sd_miso,
  output logic        sd_cs_n
`ifdef SD_SPI_CTRL_IRQ_EN
  ,
  output logic        irq
`endif
);

  spi_state_t       state;
  logic [7:0]       tx_shift;
  logic [7:0]       rx_shift;
  logic [7:0]       rx_byte;
  logic [2:0]       bit_cnt;
  logic             busy;
  logic             done;
  logic [DIV_W-1:0] div_reg;
  logic             tick;
`ifdef SD_SPI_CTRL_IRQ_EN
  logic             irq_en;
`endif

  logic wr_en, data_wr, data_rd, start, xfer_done;
  // Only part of the write bus is decoded; fold the rest into a sink.
  logic unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign data_wr      = wr_en && (address == ADDR_DATA);
  assign data_rd      = chipselect && !read_n && (address == ADDR_DATA);
  assign start        = data_wr && (state == IDLE);
  assign xfer_done    = tick && (state == HIGH) && (bit_cnt == 3'd7);
  assign sd_mosi      = tx_shift[7];
  assign unused_wdata = ^writedata;

  audio_nios_sd_spi_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (state != IDLE),
    .div     (div_reg),
    .tick    (tick)
  );

  // Bit-clock FSM: one sd_clk phase per divider tick, 8 bits per transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sd_clk   <= 1'b0;
      tx_shift <= 8'hFF;
      rx_shift <= 8'h00;
      rx_byte  <= 8'h00;
      bit_cnt  <= 3'd0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tx_shift <= writedata[7:0];
            bit_cnt  <= 3'd0;
            busy     <= 1'b1;
            state    <= LOW;
          end
        end
        LOW: begin
          if (tick) begin
            sd_clk   <= 1'b1;
            rx_shift <= {rx_shift[6:0], sd_miso};
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            sd_clk <= 1'b0;
            if (bit_cnt == 3'd7) begin
              busy     <= 1'b0;
              rx_byte  <= rx_shift;
              tx_shift <= 8'hFF;
              state    <= IDLE;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              tx_shift <= {tx_shift[6:0], 1'b1};
              state    <= LOW;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Software-visible registers; done set has priority over the read clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sd_cs_n <= 1'b1;
      div_reg <= DIV_W'(DIV_RESET);
      done    <= 1'b0;
`ifdef SD_SPI_CTRL_IRQ_EN
      irq_en  <= 1'b0;
`endif
    end else begin
      if (wr_en && (address == ADDR_CONTROL)) begin
        sd_cs_n <= writedata[CONTROL_CS_N_BIT];
`ifdef SD_SPI_CTRL_IRQ_EN
        irq_en  <= writedata[CONTROL_IRQ_EN_BIT];
`endif
      end
      if (wr_en && (address == ADDR_DIVIDER)) begin
        div_reg <= writedata[DIV_W-1:0];
      end
      if (xfer_done) begin
        done <= 1'b1;
      end else if (data_rd) begin
        done <= 1'b0;
      end
    end
  end

`ifdef SD_SPI_CTRL_IRQ_EN
  // Registered interrupt; the DATA read that clears done drops it at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= done && irq_en && !data_rd;
    end
  end
`endif

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[7:0] = rx_byte;
      ADDR_STATUS: begin
        readdata[STATUS_BUSY_BIT] = busy;
        readdata[STATUS_DONE_BIT] = done;
      end
      ADDR_CONTROL: begin
        readdata[CONTROL_CS_N_BIT] = sd_cs_n;
`ifdef SD_SPI_CTRL_IRQ_EN
        readdata[CONTROL_IRQ_EN_BIT] = irq_en;
`endif
      end
      ADDR_DIVIDER: readdata = 32'(div_reg);
      default:      readdata = '0;
    endcase
  end

endmodule
